count_bcd_converter: RTL and testbench

//  Downstream stage of the 8-bit counter (SUMADOR8BITS). Samples the counter's out/cout
//  and converts the binary count to packed BCD with a serial shift-add-3 (double-dabble)

---
 rtl/count_bcd_converter.sv | 168 ++++++++++++++++
 tb/tb_count_bcd_converter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_bcd_converter.sv
// rtl/count_bcd_converter.sv - serial double-dabble binary-to-BCD stage with saturating wrap counter
// Optional digit-scan 7-segment driver enabled by defining BCD_SEG_EN.
module count_bcd_converter #(
    parameter int WIDTH     = 8,
    parameter int DIGITS    = 3,
    parameter int OVF_BITS  = 4,
    parameter int SCAN_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  cout_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [OVF_BITS-1:0]   ovf_cnt
`ifdef BCD_SEG_EN
    ,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [WIDTH-1:0]    bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                valid_q, valid_d;
    logic                cout_prev_q, cout_prev_d;
    logic [OVF_BITS-1:0] ovf_q, ovf_d;
    logic [BCD_W-1:0]    adj;
    logic [3:0]          nib;

    // Add-3 correction for every nibble in the same cycle, ahead of the shift.
    always_comb begin
        adj = '0;
        nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = scratch_q[4*i +: 4];
            adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_sr_d  = bin_sr_q;
        scratch_d = scratch_q;
        bit_cnt_d = bit_cnt_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_sr_d  = count_in;
                    scratch_d = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[BCD_W-2:0], bin_sr_q[WIDTH-1]};
                bin_sr_d  = bin_sr_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                // Result is published on entry to DONE so bcd_out is fresh while valid is high.
                if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    bcd_d   = scratch_d;
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cout_prev_d = cout_in;
        ovf_d       = ovf_q;
        if (cout_in && !cout_prev_q && (ovf_q != {OVF_BITS{1'b1}})) begin
            ovf_d = ovf_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_sr_q    <= '0;
            scratch_q   <= '0;
            bit_cnt_q   <= '0;
            bcd_q       <= '0;
            valid_q     <= 1'b0;
            cout_prev_q <= 1'b0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            bin_sr_q    <= bin_sr_d;
            scratch_q   <= scratch_d;
            bit_cnt_q   <= bit_cnt_d;
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            cout_prev_q <= cout_prev_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign valid   = valid_q;
    assign bcd_out = bcd_q;
    assign ovf_cnt = ovf_q;

`ifdef BCD_SEG_EN
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           seg_nib;

    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == {SCAN_BITS{1'b1}}) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        seg_nib = bcd_q[4*idx_q +: 4];
        dig_sel = DIGITS'(1) << idx_q;
        case (seg_nib)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end
`endif

endmodule

// File: tb/tb_count_bcd_converter.sv
// tb/tb_count_bcd_converter.sv - scoreboard bench for count_bcd_converter
module tb_count_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  count_in;
    logic        cout_in;
    logic        start;
    logic        busy;
    logic        valid;
    logic [11:0] bcd_out;
    logic [3:0]  ovf_cnt;
`ifdef BCD_SEG_EN
    logic [6:0]  seg;
    logic [2:0]  dig_sel;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [11:0] sb[$];
    logic [11:0] mon_exp;

    count_bcd_converter #(
        .WIDTH(8), .DIGITS(3), .OVF_BITS(4), .SCAN_BITS(2)
    ) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .cout_in(cout_in), .start(start),
        .busy(busy), .valid(valid), .bcd_out(bcd_out), .ovf_cnt(ovf_cnt)
`ifdef BCD_SEG_EN
        , .seg(seg), .dig_sel(dig_sel)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: bcd_out=%h, required no valid pulse", bcd_out);
            end else begin
                mon_exp = sb.pop_front();
                if (bcd_out !== mon_exp) begin
                    errors++;
                    $display("FAIL bcd_result: got %h, required %h", bcd_out, mon_exp);
                end
            end
        end
    end

    task automatic start_conv(input logic [7:0] v);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        count_in = v;
        start    = 1'b1;
        sb.push_back(ref_bcd(int'(v)));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cout_in = 1'b0; count_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, valid, bcd_out, ovf_cnt} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b bcd=%h ovf=%0d, required all zero",
                     busy, valid, bcd_out, ovf_cnt);
        end
`ifdef BCD_SEG_EN
        checks++;
        if (dig_sel !== 3'b001 || seg !== 7'h3F) begin
            errors++;
            $display("FAIL reset_seg: dig_sel=%b seg=%h, required 001/3f", dig_sel, seg);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_latency();
        int lat;
        @(negedge clk);
        count_in = 8'd0;
        start    = 1'b1;
        sb.push_back(ref_bcd(0));
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL latency: got %0d clocks, required 9", lat);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL post_valid: busy=%b valid=%b, required 0/0", busy, valid);
        end
    endtask

    task automatic test_values();
        logic [7:0] vals [3];
        vals[0] = 8'd255; vals[1] = 8'd99; vals[2] = 8'd100;
        for (int i = 0; i < 3; i++) begin
            start_conv(vals[i]);
            wait_drain();
            checks++;
            if (sb.size() !== 0) begin
                errors++;
                $display("FAIL value_drain: %0d results outstanding, required 0", sb.size());
            end
            repeat (3) @(negedge clk);
            checks++;
            if (bcd_out !== ref_bcd(int'(vals[i]))) begin
                errors++;
                $display("FAIL value_hold: got %h, required %h", bcd_out, ref_bcd(int'(vals[i])));
            end
        end
    endtask

    task automatic test_back_to_back();
        int last;
        int nv;
        last = -1;
        nv   = 0;
        count_in = 8'd42;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (valid) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last !== 10) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d clocks, required 10", i - last);
                    end
                end
                last = i;
                nv++;
            end
            start = (i < 40);
            if (start && !busy) sb.push_back(ref_bcd(42));
        end
        start = 1'b0;
        wait_drain();
        checks++;
        if (nv < 4 || sb.size() !== 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d valids with %0d outstanding, required >=4 and 0",
                     nv, sb.size());
        end
    endtask

    task automatic test_busy_ignore();
        start_conv(8'd7);
        count_in = 8'd200;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = (i % 2 == 0);
        end
        start = 1'b0;
        wait_drain();
        repeat (15) @(negedge clk);
        checks++;
        if (sb.size() !== 0 || bcd_out !== 12'h007) begin
            errors++;
            $display("FAIL busy_ignore: bcd=%h outstanding=%0d, required 007 and 0",
                     bcd_out, sb.size());
        end
    endtask

    task automatic test_abort();
        int nv;
        start_conv(8'd123);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || bcd_out !== 12'h000) begin
            errors++;
            $display("FAIL abort_state: busy=%b bcd=%h, required 0/000", busy, bcd_out);
        end
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL abort_no_valid: got %0d pulses, required 0", nv);
        end
    endtask

    task automatic test_ovf();
        @(negedge clk);
        checks++;
        if (ovf_cnt !== 4'd0) begin
            errors++;
            $display("FAIL ovf_start: got %0d, required 0", ovf_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            cout_in = 1'b1;
            @(negedge clk);
            cout_in = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (ovf_cnt !== 4'd3) begin
            errors++;
            $display("FAIL ovf_pulses: got %0d, required 3", ovf_cnt);
        end
        cout_in = 1'b1;
        repeat (5) @(negedge clk);
        cout_in = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf_cnt !== 4'd4) begin
            errors++;
            $display("FAIL ovf_level: got %0d, required 4", ovf_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            cout_in = 1'b1;
            @(negedge clk);
            cout_in = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (ovf_cnt !== 4'd15) begin
            errors++;
            $display("FAIL ovf_saturate: got %0d, required 15", ovf_cnt);
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 256; v++) begin
            start_conv(8'(v));
            wait_drain();
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sweep_drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

`ifdef BCD_SEG_EN
    task automatic test_seg();
        logic [11:0] val;
        logic [2:0]  prev;
        logic [3:0]  n;
        int          run;
        int          first;
        val = 12'h255;
        start_conv(8'd255);
        wait_drain();
        @(negedge clk);
        prev  = dig_sel;
        run   = 0;
        first = 1;
        for (int i = 0; i < 30; i++) begin
            if (dig_sel !== prev) begin
                checks++;
                if ((!first && run !== 4) || dig_sel !== {prev[1:0], prev[2]}) begin
                    errors++;
                    $display("FAIL seg_scan: dig_sel %b->%b after %0d clocks, required rotate after 4",
                             prev, dig_sel, run);
                end
                first = 0;
                run   = 0;
                prev  = dig_sel;
            end
            n = (dig_sel == 3'b001) ? val[3:0] : (dig_sel == 3'b010) ? val[7:4] : val[11:8];
            checks++;
            if (seg !== ref_seg(n)) begin
                errors++;
                $display("FAIL seg_decode: dig_sel=%b seg=%h, required %h", dig_sel, seg, ref_seg(n));
            end
            run++;
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_values();
        test_back_to_back();
        test_busy_ignore();
        test_abort();
        test_ovf();
        test_sweep();
`ifdef BCD_SEG_EN
        test_seg();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
